// File: rtl/liteic_master_node_write.sv
// Master-side write node: decodes one AW+W to a one-hot crossbar slot,
// returns the selected slave's B response, or answers DECERR locally.
module liteic_master_node_write #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter logic [NUM_SLAVES-1:0] WR_CONNECTIVITY = '1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [ADDR_WIDTH-1:0]                  s_aw_addr_i,
  input  logic [3:0]                             s_aw_qos_i,
  input  logic                                   s_aw_valid_i,
  output logic                                   s_aw_ready_o,
  input  logic [DATA_WIDTH-1:0]                  s_w_data_i,
  input  logic [DATA_WIDTH/8-1:0]                s_w_strb_i,
  input  logic                                   s_w_valid_i,
  output logic                                   s_w_ready_o,
  output logic [1:0]                             s_b_resp_o,
  output logic                                   s_b_valid_o,
  input  logic                                   s_b_ready_i,
  output logic [ADDR_WIDTH-1:0]                  cbar_aw_data_o,
  output logic [3:0]                             cbar_aw_qos_o,
  output logic [NUM_SLAVES-1:0]                  cbar_aw_val_o,
  input  logic [NUM_SLAVES-1:0]                  cbar_aw_rdy_i,
  output logic [DATA_WIDTH+DATA_WIDTH/8-1:0]     cbar_w_data_o,
  output logic [NUM_SLAVES-1:0]                  cbar_w_val_o,
  input  logic [NUM_SLAVES-1:0]                  cbar_w_rdy_i,
  input  logic [2*NUM_SLAVES-1:0]                cbar_b_data_i,
  input  logic [NUM_SLAVES-1:0]                  cbar_b_val_i,
  output logic [NUM_SLAVES-1:0]                  cbar_b_rdy_o
);

  localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

  typedef enum logic [2:0] {IDLE, FWD, DERR, BWAIT, BRESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              qos_q, qos_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [1:0]              resp_q, resp_d;

  logic [SEL_WIDTH-1:0]    sel_in;
  logic [NUM_SLAVES-1:0]   sel_oh, in_oh;
  logic                    aw_rdy_sel, w_rdy_sel, b_val_sel;
  logic                    aw_hs, w_hs;
  logic [1:0]              b_sel;

  // Shifting past the vector width yields zero, so out-of-range selects decode as unmapped.
  assign sel_in     = s_aw_addr_i[ADDR_WIDTH-1 -: SEL_WIDTH];
  assign sel_oh     = ONE << sel_q;
  assign in_oh      = ONE << sel_in;
  assign aw_rdy_sel = |(cbar_aw_rdy_i & sel_oh);
  assign w_rdy_sel  = |(cbar_w_rdy_i & sel_oh);
  assign b_val_sel  = |(cbar_b_val_i & sel_oh);
  assign aw_hs      = (state_q == FWD) && !aw_done_q && aw_rdy_sel;
  assign w_hs       = (state_q == FWD) && !w_done_q && s_w_valid_i && w_rdy_sel;

  always_comb begin
    b_sel = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (sel_oh[s]) b_sel = cbar_b_data_i[2*s +: 2];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      qos_q     <= '0;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      qos_q     <= qos_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    qos_d     = qos_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (s_aw_valid_i) begin
          addr_d    = s_aw_addr_i;
          qos_d     = s_aw_qos_i;
          sel_d     = sel_in;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = |(WR_CONNECTIVITY & in_oh) ? FWD : DERR;
        end
      end
      FWD: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = BWAIT;
      end
      DERR: begin
        if (s_w_valid_i) begin
          resp_d  = 2'b11;
          state_d = BRESP;
        end
      end
      BWAIT: begin
        if (b_val_sel) begin
          resp_d  = b_sel;
          state_d = BRESP;
        end
      end
      BRESP: begin
        if (s_b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_aw_ready_o  = 1'b0;
    s_w_ready_o   = 1'b0;
    s_b_valid_o   = 1'b0;
    cbar_aw_val_o = '0;
    cbar_w_val_o  = '0;
    cbar_w_data_o = '0;
    cbar_b_rdy_o  = '0;
    case (state_q)
      IDLE:  s_aw_ready_o = 1'b1;
      FWD: begin
        if (!aw_done_q) cbar_aw_val_o = sel_oh;
        if (!w_done_q) begin
          cbar_w_val_o  = s_w_valid_i ? sel_oh : '0;
          s_w_ready_o   = w_rdy_sel;
          cbar_w_data_o = {s_w_strb_i, s_w_data_i};
        end
      end
      DERR:  s_w_ready_o  = 1'b1;
      BWAIT: cbar_b_rdy_o = sel_oh;
      BRESP: s_b_valid_o  = 1'b1;
      default: ;
    endcase
  end

  assign s_b_resp_o     = resp_q;
  assign cbar_aw_data_o = addr_q;
  assign cbar_aw_qos_o  = qos_q;

endmodule

// File: tb/tb_liteic_master_node_write.sv
// Bench for liteic_master_node_write: two instances (full and partial
// connectivity) share stimulus and are checked against a transaction model.
module tb_liteic_master_node_write;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_aw_addr;
  logic [3:0]  s_aw_qos;
  logic        s_aw_valid;
  logic [31:0] s_w_data;
  logic [3:0]  s_w_strb;
  logic        s_w_valid;
  logic        s_b_ready;
  logic [3:0]  cbar_aw_rdy, cbar_w_rdy, cbar_b_val;
  logic [7:0]  cbar_b_data;

  logic        aw_ready [2];
  logic        w_ready  [2];
  logic        b_valid  [2];
  logic [1:0]  b_resp   [2];
  logic [31:0] aw_data  [2];
  logic [3:0]  aw_qos   [2];
  logic [3:0]  aw_val   [2];
  logic [3:0]  w_val    [2];
  logic [3:0]  b_rdy    [2];
  logic [35:0] w_data   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  liteic_master_node_write #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4),
                             .WR_CONNECTIVITY(4'b1111)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .s_aw_addr_i(s_aw_addr), .s_aw_qos_i(s_aw_qos), .s_aw_valid_i(s_aw_valid), .s_aw_ready_o(aw_ready[0]),
    .s_w_data_i(s_w_data), .s_w_strb_i(s_w_strb), .s_w_valid_i(s_w_valid), .s_w_ready_o(w_ready[0]),
    .s_b_resp_o(b_resp[0]), .s_b_valid_o(b_valid[0]), .s_b_ready_i(s_b_ready),
    .cbar_aw_data_o(aw_data[0]), .cbar_aw_qos_o(aw_qos[0]), .cbar_aw_val_o(aw_val[0]), .cbar_aw_rdy_i(cbar_aw_rdy),
    .cbar_w_data_o(w_data[0]), .cbar_w_val_o(w_val[0]), .cbar_w_rdy_i(cbar_w_rdy),
    .cbar_b_data_i(cbar_b_data), .cbar_b_val_i(cbar_b_val), .cbar_b_rdy_o(b_rdy[0]));

  liteic_master_node_write #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4),
                             .WR_CONNECTIVITY(4'b1011)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .s_aw_addr_i(s_aw_addr), .s_aw_qos_i(s_aw_qos), .s_aw_valid_i(s_aw_valid), .s_aw_ready_o(aw_ready[1]),
    .s_w_data_i(s_w_data), .s_w_strb_i(s_w_strb), .s_w_valid_i(s_w_valid), .s_w_ready_o(w_ready[1]),
    .s_b_resp_o(b_resp[1]), .s_b_valid_o(b_valid[1]), .s_b_ready_i(s_b_ready),
    .cbar_aw_data_o(aw_data[1]), .cbar_aw_qos_o(aw_qos[1]), .cbar_aw_val_o(aw_val[1]), .cbar_aw_rdy_i(cbar_aw_rdy),
    .cbar_w_data_o(w_data[1]), .cbar_w_val_o(w_val[1]), .cbar_w_rdy_i(cbar_w_rdy),
    .cbar_b_data_i(cbar_b_data), .cbar_b_val_i(cbar_b_val), .cbar_b_rdy_o(b_rdy[1]));

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding write per instance.
  typedef struct {
    bit          busy, err, aws, ws, bgot;
    int unsigned sel;
    logic [31:0] addr;
    logic [3:0]  qos;
    logic [1:0]  resp;
  } mdl_t;
  mdl_t m [2];

  function automatic bit connected(input int k, input int unsigned sel);
    logic [3:0] c;
    c = (k == 0) ? 4'b1111 : 4'b1011;
    return (sel < 4) ? c[sel] : 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k] = '{0, 0, 0, 0, 0, 0, '0, '0, '0};
      end else if (!m[k].busy) begin
        if (s_aw_valid) begin
          m[k].busy = 1; m[k].aws = 0; m[k].ws = 0; m[k].bgot = 0;
          m[k].addr = s_aw_addr; m[k].qos = s_aw_qos;
          m[k].sel  = int'(s_aw_addr[31:28]);
          m[k].err  = !connected(k, m[k].sel);
        end
      end else if (m[k].bgot) begin
        if (s_b_ready) m[k].busy = 0;
      end else if (m[k].err) begin
        if (s_w_valid) begin m[k].bgot = 1; m[k].resp = 2'b11; end
      end else if (!(m[k].aws && m[k].ws)) begin
        if (!m[k].aws && cbar_aw_rdy[m[k].sel]) m[k].aws = 1;
        if (!m[k].ws && s_w_valid && cbar_w_rdy[m[k].sel]) m[k].ws = 1;
      end else if (cbar_b_val[m[k].sel]) begin
        m[k].bgot = 1;
        m[k].resp = cbar_b_data[2*m[k].sel +: 2];
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        bit fwd, bw, de;
        logic [3:0] oh;
        fwd = m[k].busy && !m[k].err && !m[k].bgot && !(m[k].aws && m[k].ws);
        bw  = m[k].busy && !m[k].err && !m[k].bgot && m[k].aws && m[k].ws;
        de  = m[k].busy && m[k].err && !m[k].bgot;
        oh  = (m[k].sel < 4) ? 4'(1 << m[k].sel) : 4'b0;
        chk("aw_ready", k, aw_ready[k], !m[k].busy);
        chk("w_ready", k, w_ready[k], de ? 1'b1 : (fwd && !m[k].ws) ? |(cbar_w_rdy & oh) : 1'b0);
        chk("aw_val", k, aw_val[k], (fwd && !m[k].aws) ? oh : 4'b0);
        chk("w_val", k, w_val[k], (fwd && !m[k].ws && s_w_valid) ? oh : 4'b0);
        chk("w_data", k, w_data[k], (fwd && !m[k].ws) ? {s_w_strb, s_w_data} : 36'h0);
        chk("b_rdy", k, b_rdy[k], bw ? oh : 4'b0);
        chk("b_valid", k, b_valid[k], m[k].busy && m[k].bgot);
        if (m[k].busy && m[k].bgot) chk("b_resp", k, b_resp[k], m[k].resp);
        chk("aw_data", k, aw_data[k], m[k].addr);
        chk("aw_qos", k, aw_qos[k], m[k].qos);
      end
    end
  end

  task automatic idle_inputs();
    s_aw_addr = '0; s_aw_qos = '0; s_aw_valid = 0;
    s_w_data = '0; s_w_strb = '0; s_w_valid = 0; s_b_ready = 0;
    cbar_aw_rdy = '0; cbar_w_rdy = '0; cbar_b_val = '0; cbar_b_data = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_aw, cnt_w, cnt_x, n;
    int unsigned r;
    idle_inputs();
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_aw_ready", k, aw_ready[k], 1'b1);
      chk("rst_b_valid", k, b_valid[k], 1'b0);
      chk("rst_aw_data", k, aw_data[k], 32'h0);
    end
    @(negedge clk); rst = 0;

    // Slave 2, immediate ready; dut1 has no route to slave 2.
    @(negedge clk);
    s_aw_valid = 1; s_aw_addr = 32'h2000_0010; s_aw_qos = 4'd5;
    s_w_valid = 1; s_w_data = 32'hDEADBEEF; s_w_strb = 4'hF;
    cbar_aw_rdy = 4'b0100; cbar_w_rdy = 4'b0100; cbar_b_data = 8'hCF;
    #2 chk("t1_w_ready_idle", 0, w_ready[0], 1'b0);
    @(negedge clk); s_aw_valid = 0;
    #2;
    chk("t1_aw_val", 0, aw_val[0], 4'b0100);
    chk("t1_qos", 0, aw_qos[0], 4'd5);
    chk("t1_w_data", 0, w_data[0], 36'hF_DEADBEEF);
    chk("t1_noconn_aw_val", 1, aw_val[1], 4'b0000);
    chk("t1_noconn_w_ready", 1, w_ready[1], 1'b1);
    @(negedge clk); s_w_valid = 0; cbar_b_val = 4'b0100;
    #2;
    chk("t1_b_rdy", 0, b_rdy[0], 4'b0100);
    chk("t1_b_valid_early", 0, b_valid[0], 1'b0);
    chk("t1_noconn_resp", 1, b_resp[1], 2'b11);
    @(negedge clk); cbar_b_val = 0;
    #2;
    chk("t1_b_valid", 0, b_valid[0], 1'b1);
    chk("t1_b_resp", 0, b_resp[0], 2'b00);
    @(negedge clk); s_b_ready = 1;
    @(negedge clk); s_b_ready = 0;

    // Slave 1 stalls AW for 5 cycles while W completes first.
    @(negedge clk);
    s_aw_valid = 1; s_aw_addr = 32'h1000_0000; s_aw_qos = 4'd3;
    s_w_valid = 1; s_w_data = 32'h1234_5678; s_w_strb = 4'h3;
    cbar_aw_rdy = 0; cbar_w_rdy = 4'b0010; cbar_b_data = 8'h00;
    cnt_aw = 0; cnt_w = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) s_aw_valid = 0;
      if (i == 5) cbar_aw_rdy = 4'b0010;
      #2;
      if (aw_val[0] == 4'b0010 && aw_data[0] == 32'h1000_0000) cnt_aw++;
      if (w_val[0] != 0 && w_ready[0]) cnt_w++;
    end
    chk("t2_aw_cycles", 0, cnt_aw, 6);
    chk("t2_w_beats", 0, cnt_w, 1);
    @(negedge clk); s_w_valid = 0; cbar_b_val = 4'b0010; s_b_ready = 1;
    @(negedge clk); cbar_b_val = 0;
    #2 chk("t2_b_valid", 0, b_valid[0], 1'b1);

    // Unmapped select 7: local DECERR, one W beat, no crossbar activity.
    @(negedge clk);
    s_b_ready = 0; s_aw_valid = 1; s_aw_addr = 32'h7000_0000;
    s_w_valid = 1; cbar_aw_rdy = '1; cbar_w_rdy = '1; cbar_b_val = '1;
    cnt_x = 0; cnt_w = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) s_aw_valid = 0;
      if (i == 1) s_w_valid = 0;
      #2;
      if ((aw_val[0] | w_val[0] | b_rdy[0]) != 0) cnt_x++;
      if (s_w_valid && w_ready[0]) cnt_w++;
    end
    chk("t3_cbar_activity", 0, cnt_x, 0);
    chk("t3_w_beats", 0, cnt_w, 1);
    chk("t3_b_resp", 0, b_resp[0], 2'b11);
    @(negedge clk); s_b_ready = 1; cbar_aw_rdy = 0; cbar_w_rdy = 0; cbar_b_val = 0;
    @(negedge clk); s_b_ready = 0;

    // SLVERR held while master stalls B; next AW waits for the B handshake.
    @(negedge clk);
    s_aw_valid = 1; s_aw_addr = 32'h0000_0040; s_w_valid = 1;
    cbar_aw_rdy = 4'b0001; cbar_w_rdy = 4'b0001; cbar_b_data = 8'h02;
    @(negedge clk); s_aw_valid = 0;
    @(negedge clk); s_w_valid = 0; cbar_b_val = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin cbar_b_val = 0; s_aw_valid = 1; s_aw_addr = 32'h3000_0100; end
      #2;
      chk("t5_b_valid", 0, b_valid[0], 1'b1);
      chk("t5_b_resp", 0, b_resp[0], 2'b10);
      chk("t5_aw_blocked", 0, aw_ready[0], 1'b0);
    end
    @(negedge clk); s_b_ready = 1;
    #2 chk("t5_aw_blocked_last", 0, aw_ready[0], 1'b0);
    @(negedge clk);
    s_b_ready = 0; s_w_valid = 1; cbar_aw_rdy = 4'b1000; cbar_w_rdy = 4'b1000;
    #2 chk("t5_aw_ready_after_b", 0, aw_ready[0], 1'b1);
    @(negedge clk); s_aw_valid = 0;

    // Reset while waiting for B from slave 3.
    @(negedge clk); s_w_valid = 0;
    #2 chk("t6_b_rdy_pre", 0, b_rdy[0], 4'b1000);
    #1 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_b_rdy_rst", k, b_rdy[k], 4'b0);
      chk("t6_vals_rst", k, {aw_val[k], w_val[k]}, 8'h0);
      chk("t6_b_valid_rst", k, b_valid[k], 1'b0);
      chk("t6_aw_ready_rst", k, aw_ready[k], 1'b1);
    end
    @(negedge clk); rst = 0; idle_inputs();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 5);
      if (r >= 4) r = $urandom_range(4, 15);
      s_aw_addr = $urandom();
      s_aw_addr[31:28] = r[3:0];
      s_aw_valid  = ($urandom_range(0, 2) == 0);
      s_aw_qos    = 4'($urandom());
      s_w_valid   = 1'($urandom_range(0, 1));
      s_w_data    = $urandom();
      s_w_strb    = 4'($urandom());
      cbar_aw_rdy = 4'($urandom());
      cbar_w_rdy  = 4'($urandom());
      cbar_b_val  = 4'($urandom());
      cbar_b_data = 8'($urandom());
      s_b_ready   = ($urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    rst = 0; idle_inputs();
    s_w_valid = 1; cbar_aw_rdy = '1; cbar_w_rdy = '1; cbar_b_val = '1; s_b_ready = 1;
    n = 0;
    #2;
    while (!(aw_ready[0] && aw_ready[1]) && n < 40) begin
      @(negedge clk); #2; n++;
    end
    chk("drain_idle", 0, (aw_ready[0] && aw_ready[1]), 1'b1);
    @(negedge clk); idle_inputs();
    @(negedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/liteic_master_node_write.md
Name: liteic_master_node_write

Overview:
Master-side write node of the AXI-lite interconnect, one instance per master slot, sitting directly upstream of the slave-side write nodes.
- Accepts one write (AW + W) from its master and decodes the address to a slave slot.
- Drives a one-hot AW/W request with QoS into the crossbar, collects the B response from the selected slave and returns it to the master.
- Unmapped or unconnected addresses are answered locally with DECERR.
- One outstanding transaction at a time.

Parameters:
NUM_SLAVES, 4, number of slave slots on the crossbar (1..16).
ADDR_WIDTH, 32, AW address width.
DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8.
SEL_WIDTH, 4, upper address bits used as slave index, addr[ADDR_WIDTH-1 -: SEL_WIDTH]; must satisfy 2**SEL_WIDTH >= NUM_SLAVES.
WR_CONNECTIVITY, all ones, NUM_SLAVES-bit vector; bit s=1 means this master may write slave s.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous active-high reset.
s_aw_addr_i  in  ADDR_WIDTH  master write address.
s_aw_qos_i  in  4  master write QoS.
s_aw_valid_i / s_aw_ready_o  in/out  1  AW handshake.
s_w_data_i  in  DATA_WIDTH  write data.
s_w_strb_i  in  DATA_WIDTH/8  write strobes.
s_w_valid_i / s_w_ready_o  in/out  1  W handshake.
s_b_resp_o  out  2  write response.
s_b_valid_o / s_b_ready_i  out/in  1  B handshake.
cbar_aw_data_o  out  ADDR_WIDTH  latched address (broadcast).
cbar_aw_qos_o  out  4  latched QoS (broadcast).
cbar_aw_val_o / cbar_aw_rdy_i  out/in  NUM_SLAVES  one-hot AW request/ready.
cbar_w_data_o  out  DATA_WIDTH+DATA_WIDTH/8  {strb,data}.
cbar_w_val_o / cbar_w_rdy_i  out/in  NUM_SLAVES  one-hot W request/ready.
cbar_b_data_i  in  2*NUM_SLAVES  per-slave bresp, slave s at bits [2s+1:2s].
cbar_b_val_i / cbar_b_rdy_o  in/out  NUM_SLAVES  per-slave B valid/ready.

Behaviour:
Reset:
- FSM goes to IDLE; address, QoS, select, bresp and done flags clear.
- All valid/ready outputs are 0 except s_aw_ready_o (1 in IDLE); data outputs are 0.
- Reset mid-transaction aborts immediately; no response is issued.

FSM states: IDLE, FWD, DERR, BWAIT, BRESP.

IDLE:
- s_aw_ready_o=1, s_w_ready_o=0.
- On AW handshake: latch addr, qos, sel=addr[ADDR_WIDTH-1 -: SEL_WIDTH]; clear aw_done and w_done.
- If sel<NUM_SLAVES and WR_CONNECTIVITY[sel]=1, go to FWD; else go to DERR.

FWD:
- cbar_aw_val_o = (1<<sel) while !aw_done; aw_done sets on the cbar_aw_rdy_i[sel] handshake.
- W is a combinational pass-through while !w_done: cbar_w_val_o[sel]=s_w_valid_i, s_w_ready_o=cbar_w_rdy_i[sel], cbar_w_data_o={s_w_strb_i,s_w_data_i}. w_done sets on the handshake.
- AW and W may complete in either order or in the same cycle.
- When both are done (including the same cycle as the last handshake), go to BWAIT.
- First cbar_aw_val_o is one cycle after the master AW handshake.

DERR:
- s_w_ready_o=1 until one W beat is accepted (data dropped); no crossbar request is made.
- Then go to BRESP with resp=2'b11 (DECERR).

BWAIT:
- cbar_b_rdy_o=(1<<sel).
- On cbar_b_val_i[sel]: latch cbar_b_data_i[2sel+1:2sel] and go to BRESP.
- cbar_b_val_i on other indices is ignored; their rdy stays 0.

BRESP:
- s_b_valid_o=1, s_b_resp_o=latched resp, both held stable until s_b_ready_i; then go to IDLE.
- B latency: s_b_valid_o one cycle after the crossbar B handshake.

General:
- In states other than IDLE, s_aw_ready_o=0; a pending master AW waits.
- cbar_aw_data_o and cbar_aw_qos_o hold the latched values from AW acceptance until the next AW acceptance.
- cbar_*_val_o are never asserted for more than one bit.
- cbar_w_val_o=0 outside FWD.
- Master W asserted before AW is held off (s_w_ready_o=0 in IDLE).

Test Plan:
- AW addr=0x2000_0010 qos=5, W data=0xDEADBEEF strb=0xF, slave 2 ready immediately, bresp=00 -> cbar_aw_val_o=0100 one cycle after the AW handshake; cbar_aw_qos_o=5; cbar_w_data_o=0xF_DEADBEEF; s_b_valid_o with resp 00 one cycle after the crossbar B handshake.
- Slave 1 holds cbar_aw_rdy_i low for 5 cycles, W accepted first -> cbar_aw_val_o=0010 held 6 cycles with stable data; only one W beat passes; transaction completes normally.
- addr=0x7000_0000 (sel=7>=NUM_SLAVES) -> no cbar_*_val_o ever asserted; one W beat consumed; s_b_resp_o=11.
- WR_CONNECTIVITY=4'b1011, addr to slave 2 -> DECERR, no crossbar activity.
- Slave returns bresp=10 while s_b_ready_i is low for 3 cycles -> s_b_valid_o/resp=10 stable; next AW is not accepted until the B handshake completes.
- rst_i asserted in BWAIT -> all cbar_*_val_o, cbar_b_rdy_o and s_b_valid_o drop to 0 asynchronously; s_aw_ready_o=1 after reset.
